// File: rtl/leaf_tx_arbiter.sv
// leaf_tx_arbiter: N-channel transmit arbiter for a BFT leaf interface.
// Each channel has a one-word holding register. A round-robin arbiter picks
// one channel per cycle and launches its word as a BFT packet. Launches are
// gated by a per-channel credit counter, which credit packets from the BFT replenish.
module leaf_tx_arbiter #(
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 4,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int PACKET_BITS   = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + 1 + PAYLOAD_BITS,
  parameter int NUM_IN_PORTS  = 4,
  parameter int CREDITS       = 64
) (
  input  logic                                                 clk_bft,
  input  logic                                                 reset_bft,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]                 din_leaf_user2interface,
  input  logic [NUM_IN_PORTS-1:0]                              vld_user2interface,
  output logic [NUM_IN_PORTS-1:0]                              ack_interface2user,
  input  logic [NUM_IN_PORTS*(NUM_LEAF_BITS+NUM_PORT_BITS)-1:0] dest_cfg,
  input  logic [PACKET_BITS-1:0]                               din_leaf_bft2interface,
  input  logic                                                 resend,
  output logic [PACKET_BITS-1:0]                               dout_leaf_interface2bft
);

  localparam int DEST_BITS = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int CRED_BITS = NUM_ADDR_BITS + 1;
  localparam int SUM_BITS  = CRED_BITS + 1;
  localparam int PTR_BITS  = (NUM_IN_PORTS > 1) ? $clog2(NUM_IN_PORTS) : 1;
  localparam int PORT_LSB  = PAYLOAD_BITS + 1 + NUM_ADDR_BITS;

  logic [PAYLOAD_BITS-1:0]  hold_word [NUM_IN_PORTS];
  logic [NUM_IN_PORTS-1:0]  hold_full;
  logic [NUM_ADDR_BITS-1:0] seq       [NUM_IN_PORTS];
  logic [CRED_BITS-1:0]     credit    [NUM_IN_PORTS];
  logic [CRED_BITS-1:0]     credit_next [NUM_IN_PORTS];
  logic [PTR_BITS-1:0]      rr_ptr;
  logic [PTR_BITS-1:0]      rr_next;

  logic [NUM_IN_PORTS-1:0]  eligible;
  logic [NUM_IN_PORTS-1:0]  grant;
  logic                     grant_any;
  logic [PTR_BITS-1:0]      grant_idx;
  logic [PACKET_BITS-1:0]   launch_pkt;

  logic                     ret_valid;
  logic [NUM_PORT_BITS-1:0] ret_port;
  logic [CRED_BITS-1:0]     ret_amount;

  // A channel is eligible when it holds a word and has credit left.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_IN_PORTS; i++) begin
      eligible[i] = hold_full[i] & (credit[i] != '0);
    end
  end

  // Round-robin search: the first eligible channel at or after rr_ptr wins. Resend blocks all grants.
  always_comb begin
    int unsigned idx;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    if (!resend) begin
      for (int unsigned k = 0; k < NUM_IN_PORTS; k++) begin
        idx = (32'(rr_ptr) + k) % NUM_IN_PORTS;
        if (!grant_any && eligible[idx]) begin
          grant_any = 1'b1;
          grant_idx = PTR_BITS'(idx);
        end
      end
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
    rr_next = (32'(grant_idx) == NUM_IN_PORTS - 1) ? '0 : grant_idx + 1'b1;
  end

  // A full holding register can accept a new word only in the cycle it launches.
  always_comb begin
    ack_interface2user = ~{NUM_IN_PORTS{reset_bft}} & (~hold_full | grant);
  end

  // Build the outgoing packet for the granted channel.
  always_comb begin
    launch_pkt = {1'b1, dest_cfg[32'(grant_idx)*DEST_BITS +: DEST_BITS],
                  seq[grant_idx], 1'b0, hold_word[grant_idx]};
  end

  // Decode the incoming credit packet. Data packets and out-of-range ports are ignored.
  always_comb begin
    ret_port   = din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS];
    ret_amount = din_leaf_bft2interface[CRED_BITS-1:0];
    ret_valid  = din_leaf_bft2interface[PACKET_BITS-1] & din_leaf_bft2interface[PAYLOAD_BITS] &
                 (32'(ret_port) < NUM_IN_PORTS);
  end

  // Credit update. A launch and a return can hit the same channel in one cycle, so both
  // are folded into one widened sum and then clamped at the credit ceiling.
  always_comb begin
    logic [SUM_BITS-1:0] sum;
    sum = '0;
    for (int unsigned i = 0; i < NUM_IN_PORTS; i++) begin
      sum = {1'b0, credit[i]} - SUM_BITS'(grant[i]);
      if (ret_valid && ret_port == NUM_PORT_BITS'(i)) begin
        sum = sum + {1'b0, ret_amount};
      end
      credit_next[i] = (sum > SUM_BITS'(CREDITS)) ? CRED_BITS'(CREDITS) : sum[CRED_BITS-1:0];
    end
  end

  // State registers: holding words, sequence numbers, credits, arbiter pointer, output packet.
  always_ff @(posedge clk_bft or posedge reset_bft) begin
    if (reset_bft) begin
      hold_full               <= '0;
      rr_ptr                  <= '0;
      dout_leaf_interface2bft <= '0;
      for (int unsigned i = 0; i < NUM_IN_PORTS; i++) begin
        hold_word[i] <= '0;
        seq[i]       <= '0;
        credit[i]    <= CRED_BITS'(CREDITS);
      end
    end else begin
      for (int unsigned i = 0; i < NUM_IN_PORTS; i++) begin
        credit[i] <= credit_next[i];
        if (grant[i]) begin
          seq[i] <= seq[i] + 1'b1;
        end
        if (vld_user2interface[i] && ack_interface2user[i]) begin
          hold_word[i] <= din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
          hold_full[i] <= 1'b1;
        end else if (grant[i]) begin
          hold_full[i] <= 1'b0;
        end
      end
      if (grant_any) begin
        rr_ptr                  <= rr_next;
        dout_leaf_interface2bft <= launch_pkt;
      end else if (!resend) begin
        dout_leaf_interface2bft <= '0;
      end
    end
  end

endmodule

// File: tb/tb_leaf_tx_arbiter.sv
// tb_leaf_tx_arbiter: scoreboard bench for leaf_tx_arbiter. Expected packets come
// from a channel-level reference model and are queued. A monitor pops and compares
// them as the DUT launches.
module tb_leaf_tx_arbiter;

  localparam int PB  = 32;
  localparam int LB  = 4;
  localparam int PTB = 4;
  localparam int AB  = 7;
  localparam int PKB = 1 + LB + PTB + AB + 1 + PB;
  localparam int N   = 4;
  localparam int CR  = 64;
  localparam int DB  = LB + PTB;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*PB-1:0]   din_user;
  logic [N-1:0]      vld;
  logic [N-1:0]      ack;
  logic [N*DB-1:0]   dest;
  logic [PKB-1:0]    din_bft;
  logic              resend;
  logic [PKB-1:0]    dout;

  always #5 clk = ~clk;

  leaf_tx_arbiter #(
    .PAYLOAD_BITS (PB),
    .NUM_LEAF_BITS(LB),
    .NUM_PORT_BITS(PTB),
    .NUM_ADDR_BITS(AB),
    .NUM_IN_PORTS (N),
    .CREDITS      (CR)
  ) dut (
    .clk_bft                (clk),
    .reset_bft              (rst),
    .din_leaf_user2interface(din_user),
    .vld_user2interface     (vld),
    .ack_interface2user     (ack),
    .dest_cfg               (dest),
    .din_leaf_bft2interface (din_bft),
    .resend                 (resend),
    .dout_leaf_interface2bft(dout)
  );

  int checks = 0;
  int errors = 0;
  int pkt_count = 0;
  logic [PKB-1:0] exp_q[$];

  // Reference model: what each channel currently holds, plus its sequence number and credit.
  bit             m_full [N];
  logic [PB-1:0]  m_word [N];
  int             m_seq  [N];
  int             m_cred [N];
  int             m_rr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 0;
      m_word[i] = '0;
      m_seq[i]  = 0;
      m_cred[i] = CR;
    end
    m_rr = 0;
  endtask

  function automatic logic [PKB-1:0] cpkt(input int port, input int amt);
    logic [PB-1:0] pl;
    pl = $urandom();
    pl[AB:0] = 8'(amt);
    return {1'b1, 4'($urandom()), 4'(port), 7'($urandom()), 1'b1, pl};
  endfunction

  // One clock cycle: predict grant, ack and the launched packet, then advance the model.
  task automatic step();
    int g;
    int p;
    int amt;
    logic [N-1:0] eack;
    #1;
    g = -1;
    if (!resend) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (g < 0 && m_full[c] && m_cred[c] > 0) g = c;
      end
    end
    for (int i = 0; i < N; i++) eack[i] = !m_full[i] || (g == i);
    check("ack", 64'(ack), 64'(eack));
    if (g >= 0) begin
      exp_q.push_back({1'b1, dest[g*DB +: DB], 7'(m_seq[g]), 1'b0, m_word[g]});
      m_seq[g]  = (m_seq[g] + 1) % 128;
      m_cred[g] = m_cred[g] - 1;
      m_full[g] = 0;
      m_rr      = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (vld[i] && eack[i]) begin
        m_word[i] = din_user[i*PB +: PB];
        m_full[i] = 1;
      end
    end
    if (din_bft[PKB-1] && din_bft[PB] && int'(din_bft[PB+1+AB +: PTB]) < N) begin
      p   = int'(din_bft[PB+1+AB +: PTB]);
      amt = int'(din_bft[AB:0]);
      m_cred[p] = (m_cred[p] + amt > CR) ? CR : m_cred[p] + amt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    check("queue empty before reset", 64'(exp_q.size()), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("async reset dout", 64'(dout), 64'd0);
    check("async reset ack", 64'(ack), 64'd0);
    vld = '0; resend = 1'b0; din_bft = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: each new packet on dout is compared with the head of the queue.
  // Under resend, dout must repeat what it showed the cycle before.
  logic [PKB-1:0] mon_last = '0;
  initial begin
    logic r;
    logic rs;
    logic [PKB-1:0] e;
    forever begin
      @(posedge clk);
      r  = resend;
      rs = rst;
      #1;
      if (!rs) begin
        if (r) begin
          check("held dout under resend", 64'(dout), 64'(mon_last));
        end else if (dout[PKB-1]) begin
          pkt_count++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected packet: got %0h expected none at %0t", dout, $time);
          end else begin
            e = exp_q.pop_front();
            check("packet", 64'(dout), 64'(e));
          end
        end
      end
      mon_last = dout;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [PKB-1:0] frozen;
    rst = 1'b1; vld = '0; resend = 1'b0; din_bft = '0; din_user = '0; dest = '0;
    model_reset();
    #1;
    check("reset dout", 64'(dout), 64'd0);
    check("reset ack", 64'(ack), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single word on channel 0 with destination {3,5}.
    dest[7:0] = {4'd3, 4'd5};
    din_user[31:0] = 32'hDEADBEEF;
    vld = 4'b0001;
    step();
    vld = '0;
    step();
    check("first packet", 64'(dout), 64'({1'b1, 4'd3, 4'd5, 7'd0, 1'b0, 32'hDEADBEEF}));
    step();
    din_user[31:0] = 32'h12345678;
    vld = 4'b0001;
    step();
    vld = '0;
    step();
    check("second packet seq", 64'(dout[PB+1 +: AB]), 64'd1);
    repeat (2) step();

    // All channels valid every cycle: round-robin at one packet per cycle.
    do_reset();
    dest = 32'($urandom());
    vld = '1;
    repeat (40) begin
      din_user = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
    end
    vld = '0;
    repeat (6) step();

    // Channel 1 alone: exactly CREDITS packets, then a return of 2 gives two more.
    do_reset();
    vld = 4'b0010;
    #1 c0 = pkt_count;
    repeat (80) begin
      din_user = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
    end
    vld = '0;
    repeat (2) step();
    #1 check("credit limit packets", 64'(pkt_count - c0), 64'd64);
    check("ack low with no credit", 64'(ack[1]), 64'd0);
    c0 = pkt_count;
    din_bft = cpkt(1, 2);
    step();
    din_bft = '0;
    vld = 4'b0010;
    repeat (10) begin
      din_user = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
    end
    vld = '0;
    repeat (2) step();
    #1 check("packets after return of 2", 64'(pkt_count - c0), 64'd2);

    // Resend mid-stream freezes dout. Arbitration then resumes in round-robin order.
    do_reset();
    vld = '1;
    repeat (10) begin
      din_user = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
    end
    frozen = dout;
    resend = 1'b1;
    repeat (5) step();
    check("dout frozen by resend", 64'(dout), 64'(frozen));
    resend = 1'b0;
    repeat (10) begin
      din_user = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
    end
    vld = '0;
    repeat (4) step();

    // Channel 2: 140 words with steady returns, so seq wraps past 127.
    do_reset();
    vld = 4'b0100;
    repeat (140) begin
      din_user = {$urandom(), $urandom(), $urandom(), $urandom()};
      din_bft = cpkt(2, 1);
      step();
    end
    vld = '0; din_bft = '0;
    repeat (3) step();

    // Channel 2 at credit 60. A return of 100 clamps to 64 packets' worth.
    do_reset();
    vld = 4'b0100;
    repeat (4) begin
      din_user = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
    end
    vld = '0;
    repeat (2) step();
    #1 c0 = pkt_count;
    din_bft = cpkt(2, 100);
    step();
    din_bft = '0;
    vld = 4'b0100;
    repeat (80) begin
      din_user = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
    end
    vld = '0;
    repeat (3) step();
    #1 check("saturated credit packets", 64'(pkt_count - c0), 64'd64);

    // Random traffic: random valids, resend, credit packets and junk packets.
    do_reset();
    repeat (1500) begin
      vld = 4'($urandom());
      din_user = {$urandom(), $urandom(), $urandom(), $urandom()};
      resend = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 2) == 0) din_bft = cpkt($urandom_range(0, 5), $urandom_range(0, 6));
      else din_bft = PKB'({$urandom(), $urandom()});
      if ($urandom_range(0, 49) == 0) dest = 32'($urandom());
      step();
    end
    vld = '0; resend = 1'b0; din_bft = '0;
    repeat (4) step();

    // Reset in the middle of a stream. The first launch after release is channel 0 with seq 0.
    dest = {4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0};
    vld = '1;
    repeat (6) begin
      din_user = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
    end
    do_reset();
    vld = '1;
    step();
    step();
    check("first grant after reset port", 64'(dout[PB+1+AB +: PTB]), 64'd0);
    check("first grant after reset seq", 64'(dout[PB+1 +: AB]), 64'd0);
    vld = '0;
    repeat (6) step();

    #1 check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
